// File: rtl/systolic_result_packer.sv
// systolic_result_packer: quantises COLS-wide accumulator rows, packs them into
// UB_W words and streams a programmed number of rows to the unified buffer
// through a first-word-fall-through FIFO.
// Optional feature: define RESULT_PACKER_RELU_EN to enable ReLU before zero-point add.
module systolic_result_packer #(
   parameter int unsigned COLS  = 3,
   parameter int unsigned ACC_W = 32,
   parameter int unsigned OUT_W = 8,
   parameter int unsigned UB_W  = 256,
   parameter int unsigned DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [7:0]            num_rows,
   input  logic [4:0]            cfg_shift,
   input  logic                  cfg_signed,
   input  logic [OUT_W-1:0]      cfg_zero_point,
   input  logic                  cfg_relu,
   input  logic                  acc_valid,
   input  logic [COLS*ACC_W-1:0] acc_data,
   output logic                  acc_ready,
   output logic                  out_valid,
   output logic [UB_W-1:0]       out_data,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           sat_count
);

   localparam int unsigned EXT_W = ACC_W + 2;
   localparam int unsigned ROW_W = COLS * OUT_W;
   localparam int unsigned ENT_W = ROW_W + 1;
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned NCL_W = $clog2(COLS + 1);

   localparam logic signed [EXT_W-1:0] S_MAX = EXT_W'((64'd1 << (OUT_W - 1)) - 64'd1);
   localparam logic signed [EXT_W-1:0] S_MIN = ~S_MAX;
   localparam logic signed [EXT_W-1:0] U_MAX = EXT_W'((64'd1 << OUT_W) - 64'd1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state, state_n;
   logic [7:0]         rows_left;
   logic [4:0]         cfg_shift_q;
   logic               cfg_signed_q;
   logic [OUT_W-1:0]   cfg_zp_q;
`ifdef RESULT_PACKER_RELU_EN
   logic               cfg_relu_q;
`else
   logic               unused_relu;
   assign unused_relu = cfg_relu;
`endif

   logic               s1_valid;
   logic               s1_last;
   logic [ROW_W-1:0]   s1_row;

   logic [ENT_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
   logic [CNT_W-1:0]   count, count_n;
   logic [ENT_W-1:0]   head_n;

   logic               start_ok_c, accept_c, push_c, pop_c, ready_n;
   logic signed [EXT_W-1:0] rnd_c, zp_ext_c, lo_c, hi_c;
   logic [ROW_W-1:0]   row_c;
   logic [NCL_W-1:0]   nclip_c;
   logic [16:0]        sat_sum_c;
   logic [15:0]        sat_n;

   // Per-column rounding shift, zero-point add and saturation of the incoming row
   always_comb begin
      logic signed [EXT_W-1:0] ext_t;
      logic signed [EXT_W-1:0] s_t;
      logic signed [EXT_W-1:0] v_t;
      logic [OUT_W-1:0]        q_t;
      ext_t    = '0;
      s_t      = '0;
      v_t      = '0;
      q_t      = '0;
      row_c    = '0;
      nclip_c  = '0;
      rnd_c    = (cfg_shift_q != 5'd0) ? (EXT_W'(1) << (cfg_shift_q - 5'd1)) : '0;
      zp_ext_c = cfg_signed_q ? {{(EXT_W-OUT_W){cfg_zp_q[OUT_W-1]}}, cfg_zp_q}
                              : {{(EXT_W-OUT_W){1'b0}}, cfg_zp_q};
      hi_c     = cfg_signed_q ? S_MAX : U_MAX;
      lo_c     = cfg_signed_q ? S_MIN : '0;
      for (int unsigned c = 0; c < COLS; c++) begin
         ext_t = {{2{acc_data[c*ACC_W + ACC_W - 1]}}, acc_data[c*ACC_W +: ACC_W]};
         s_t   = (ext_t + rnd_c) >>> cfg_shift_q;
`ifdef RESULT_PACKER_RELU_EN
         if (cfg_relu_q && s_t[EXT_W-1]) s_t = '0;
`endif
         v_t = s_t + zp_ext_c;
         if (v_t > hi_c) begin
            q_t     = hi_c[OUT_W-1:0];
            nclip_c = nclip_c + NCL_W'(1);
         end else if (v_t < lo_c) begin
            q_t     = lo_c[OUT_W-1:0];
            nclip_c = nclip_c + NCL_W'(1);
         end else begin
            q_t = v_t[OUT_W-1:0];
         end
         row_c[c*OUT_W +: OUT_W] = q_t;
      end
      sat_sum_c = 17'(sat_count) + 17'(nclip_c);
      sat_n     = sat_sum_c[16] ? 16'hFFFF : sat_sum_c[15:0];
   end

   // Handshakes, FIFO next-state, next head word and job sequencing
   always_comb begin
      start_ok_c = (state == IDLE) && start;
      accept_c   = acc_valid && acc_ready;
      push_c     = s1_valid;
      pop_c      = out_valid && out_ready;
      count_n    = count + CNT_W'(push_c) - CNT_W'(pop_c);
      rd_ptr_n   = rd_ptr + PTR_W'(pop_c);
      state_n    = state;
      case (state)
         IDLE:    if (start) state_n = (num_rows == 8'd0) ? DONE : RUN;
         RUN:     if (accept_c && rows_left == 8'd1) state_n = DRAIN;
         DRAIN:   if (!s1_valid && count_n == '0) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // Room must remain for the stage-1 row that an accept now would create
      ready_n = (state_n == RUN) && ((count_n + CNT_W'(accept_c)) < CNT_W'(DEPTH));
      if (count_n == '0)
         head_n = '0;
      else if (count == CNT_W'(pop_c))
         head_n = {s1_last, s1_row};
      else
         head_n = mem[rd_ptr_n];
   end

   // FIFO storage; contents are qualified by count so no reset is needed
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= {s1_last, s1_row};
   end

   // Control FSM, stage-1 register, FIFO pointers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rows_left    <= '0;
         cfg_shift_q  <= '0;
         cfg_signed_q <= 1'b0;
         cfg_zp_q     <= '0;
`ifdef RESULT_PACKER_RELU_EN
         cfg_relu_q   <= 1'b0;
`endif
         s1_valid     <= 1'b0;
         s1_last      <= 1'b0;
         s1_row       <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         acc_ready    <= 1'b0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_last     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sat_count    <= '0;
      end else begin
         state     <= state_n;
         acc_ready <= ready_n;
         count     <= count_n;
         rd_ptr    <= rd_ptr_n;
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         out_valid <= (count_n != '0);
         out_last  <= head_n[ENT_W-1];
         out_data  <= UB_W'(head_n[ROW_W-1:0]);
         s1_valid  <= accept_c;
         if (accept_c) begin
            s1_row  <= row_c;
            s1_last <= (rows_left == 8'd1);
         end
         done <= (state == DONE);
         if (start_ok_c) begin
            cfg_shift_q  <= cfg_shift;
            cfg_signed_q <= cfg_signed;
            cfg_zp_q     <= cfg_zero_point;
`ifdef RESULT_PACKER_RELU_EN
            cfg_relu_q   <= cfg_relu;
`endif
            rows_left    <= num_rows;
            sat_count    <= '0;
            busy         <= 1'b1;
         end else begin
            if (accept_c) begin
               rows_left <= rows_left - 8'd1;
               sat_count <= sat_n;
            end
            if (state == DONE) busy <= 1'b0;
         end
      end
   end

endmodule
